regfile_sched: RTL and testbench
================================

# regfile_sched

Access controller for the single-port `RegFile`, which performs either one dual read or one write per enabled cycle. It arbitrates between a pipeline write requester and a dual-operand read requester, and drives the `RegFile` enable, mode and address/data pins. It sequences the `RegFile` clear after reset and returns read operands through a valid/ready response channel. It sits between the decode/writeback stages and the `RegFile` instance.

## Interface
- `DATA_W`, 32, register width
- `ADDR_W`, 5, register address width (32 registers)
- `WR_BURST`, 4, maximum consecutive write grants while an eligible read waits (≥1)

- `clk`  in  1  single clock; all state on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `wr_valid`  in  1  write request
- `wr_ready`  out  1  write accepted this cycle when `wr_valid` is also high
- `wr_rd`  in  ADDR_W  write address
- `wr_data`  in  DATA_W  write data
- `rd_valid`  in  1  read request
- `rd_ready`  out  1  read accepted this cycle when `rd_valid` is also high
- `rd_rs1`, `rd_rs2`  in  ADDR_W  operand addresses
- `rsp_valid`  out  1  operand response valid
- `rsp_ready`  in  1  response consumed
- `rsp_data1`, `rsp_data2`  out  DATA_W  operand values
- `busy`  out  1  high while in INIT
- `rf_en`, `rf_reset`, `rf_rwen`  out  1  to `RegFile` `en`/`reset`/`RWen` (`RWen`=1 read, 0 write)
- `rf_rs1`, `rf_rs2`, `rf_rd`  out  ADDR_W  to `RegFile` address pins
- `rf_dataIn`  out  DATA_W  to `RegFile` `dataIn`
- `rf_readOut1`, `rf_readOut2`  in  DATA_W  from `RegFile` read outputs

## Operation
- States: INIT, RUN. `reset` low forces INIT asynchronously. INIT lasts exactly one cycle after reset release, then moves to RUN.
- INIT: `rf_en`=1, `rf_reset`=1, `busy`=1, `wr_ready`=`rd_ready`=0.
- RUN, read eligible = `rd_valid` && (!`rsp_valid` || `rsp_ready`).
- RUN grant:
  - Write granted if `wr_valid`, unless read eligible and `burst_cnt`==`WR_BURST`.
  - Otherwise read granted if eligible.
  - At most one grant per cycle.
- Write grant: `wr_ready`=1, `rf_en`=1, `rf_rwen`=0, `rf_rd`=`wr_rd`, `rf_dataIn`=`wr_data`.
- Read grant: `rd_ready`=1, `rf_en`=1, `rf_rwen`=1, `rf_rs1/2`=`rd_rs1/2`.
- No grant: `rf_en`=0.
- `burst_cnt` (saturating at `WR_BURST`):
  - Increments on a write grant while a read is eligible.
  - Clears on a read grant or when no read is eligible.
- Response:
  - `rsp_valid` is set the cycle after a read grant.
  - It clears on `rsp_valid`&&`rsp_ready` with no new read grant.
  - `rsp_data1/2` = `rf_readOut1/2` (held stable by `RegFile` because no read issues while a response is stalled).
- Reset values: `rsp_valid`=0, `burst_cnt`=0, `wr_ready`=`rd_ready`=0, `busy`=1.
- `rf_*` outputs are combinational from state and requests, with `rf_en`=1 and `rf_reset`=1 (INIT).
- Reset mid-operation: a pending response is discarded, and the `RegFile` is cleared by the following INIT cycle.

## Timing
- Write accepted in cycle N is committed at the end of N.
- Read accepted in cycle N: `rsp_valid`=1 in N+1.
- Write to register r in N, read of r granted in N+1: returns the new value.
- Simultaneous write and read requests with `burst_cnt`<`WR_BURST`: write first, read next cycle. The read therefore sees the write.
- Throughput: 1 access per cycle. Back-to-back reads are possible when `rsp_ready`=1.
- Writes proceed while a response is stalled.

## Configuration
- `REGFILE_SCHED_X0_ZERO_EN` defined:
  - A write with `wr_rd`==0 is accepted (`wr_ready`=1) but `rf_en`=0 that cycle.
  - `rsp_dataK` is forced to 0 when the captured `rs` for that port was 0. Two flag registers are captured at read grant.
- Undefined: register 0 is an ordinary register.

## Structure
- `regfile_pkg`: state enum (INIT, RUN), `DATA_W`/`ADDR_W` defaults, `RF_READ`=1/`RF_WRITE`=0 mode constants.
- Sub-module `regfile_arb`: grant logic plus `burst_cnt`.
- The top level holds the FSM, the response register and the x0 flags.

## Test plan
- Release reset → `busy`=1, `rf_en`=1, `rf_reset`=1 for one cycle, then RUN. Read x5 → `rsp_data1`=0.
- Write x3=0xDEADBEEF in N, read rs1=3, rs2=3 in N+1 → `rsp_valid` in N+2 with both data = 0xDEADBEEF.
- `wr_valid` held high for 10 cycles, `rd_valid` high, `WR_BURST`=4 → grants W,W,W,W,R,W,W,W,W,R.
- Hold `rsp_ready`=0 after a read, issue two writes → `rd_ready`=0 throughout, writes accepted, `rsp_data` unchanged.
- With macro: write x0=0x1234, read rs1=0 → `rsp_data1`=0 and `rf_en`=0 during the write. Without macro: 0x1234.
- Assert `reset` while `rsp_valid`=1 → `rsp_valid`=0 immediately (async), INIT follows, and the registers read 0 afterwards.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and constants for the RegFile access controller.
// Optional feature macro used by the controller: REGFILE_SCHED_X0_ZERO_EN.
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    // RegFile RWen encodings
    localparam logic RF_READ  = 1'b1;
    localparam logic RF_WRITE = 1'b0;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } sched_state_t;

    // Width needed to hold a count from 0 up to and including n
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/regfile_arb.sv
// Write/read grant arbiter for the single-port RegFile.
// Writes win unless a read has been starved for WR_BURST consecutive write grants.
module regfile_arb
    import regfile_pkg::*;
#(
    parameter int WR_BURST = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic wr_valid,
    input  logic rd_valid,
    input  logic rsp_valid,
    input  logic rsp_ready,
    output logic wr_grant,
    output logic rd_grant
);

    localparam int CNT_W = cnt_width(WR_BURST);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(WR_BURST);

    logic [CNT_W-1:0] burst_cnt;
    logic [CNT_W-1:0] burst_nxt;
    logic             rd_elig;
    logic             burst_full;

    // Grant selection and saturating count of writes that bypassed a waiting read
    always_comb begin
        rd_elig    = run && rd_valid && (!rsp_valid || rsp_ready);
        burst_full = (burst_cnt == BURST_MAX);
        wr_grant   = run && wr_valid && !(rd_elig && burst_full);
        rd_grant   = rd_elig && !wr_grant;
        burst_nxt  = burst_cnt;
        if (rd_grant || !rd_elig) begin
            burst_nxt = '0;
        end else if (wr_grant && !burst_full) begin
            burst_nxt = burst_cnt + CNT_W'(1);
        end
    end

    // Burst counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            burst_cnt <= '0;
        end else begin
            burst_cnt <= burst_nxt;
        end
    end

endmodule

// File: rtl/regfile_sched.sv
// Access controller for the single-port RegFile: clears it after reset, then
// arbitrates writes against dual-operand reads and returns read operands on a
// valid/ready response channel.
// Optional feature: REGFILE_SCHED_X0_ZERO_EN makes register 0 read as zero and
// silently drops writes to it.
module regfile_sched
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int WR_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_rd,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_rs1,
    input  logic [ADDR_W-1:0] rd_rs2,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data1,
    output logic [DATA_W-1:0] rsp_data2,
    output logic              busy,
    output logic              rf_en,
    output logic              rf_reset,
    output logic              rf_rwen,
    output logic [ADDR_W-1:0] rf_rs1,
    output logic [ADDR_W-1:0] rf_rs2,
    output logic [ADDR_W-1:0] rf_rd,
    output logic [DATA_W-1:0] rf_dataIn,
    input  logic [DATA_W-1:0] rf_readOut1,
    input  logic [DATA_W-1:0] rf_readOut2
);

    sched_state_t state;
    sched_state_t state_nxt;
    logic         run;
    logic         wr_grant;
    logic         rd_grant;

    assign run = (state == RUN);

    regfile_arb #(
        .WR_BURST(WR_BURST)
    ) u_arb (
        .clk      (clk),
        .reset    (reset),
        .run      (run),
        .wr_valid (wr_valid),
        .rd_valid (rd_valid),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .wr_grant (wr_grant),
        .rd_grant (rd_grant)
    );

    // State register: reset parks in INIT, which clears the RegFile for one cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and RegFile pin/handshake drive
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        wr_ready  = 1'b0;
        rd_ready  = 1'b0;
        rf_en     = 1'b0;
        rf_reset  = 1'b0;
        rf_rwen   = RF_READ;
        rf_rs1    = '0;
        rf_rs2    = '0;
        rf_rd     = '0;
        rf_dataIn = '0;
        case (state)
            INIT: begin
                state_nxt = RUN;
                busy      = 1'b1;
                rf_en     = 1'b1;
                rf_reset  = 1'b1;
            end
            RUN: begin
                if (wr_grant) begin
                    wr_ready  = 1'b1;
`ifdef REGFILE_SCHED_X0_ZERO_EN
                    rf_en     = (wr_rd != '0);
`else
                    rf_en     = 1'b1;
`endif
                    rf_rwen   = RF_WRITE;
                    rf_rd     = wr_rd;
                    rf_dataIn = wr_data;
                end else if (rd_grant) begin
                    rd_ready  = 1'b1;
                    rf_en     = 1'b1;
                    rf_rwen   = RF_READ;
                    rf_rs1    = rd_rs1;
                    rf_rs2    = rd_rs2;
                end
            end
            default: begin
                state_nxt = INIT;
            end
        endcase
    end

    // Response valid: set by a read grant, dropped once consumed without a refill
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid <= 1'b0;
        end else if (rd_grant) begin
            rsp_valid <= 1'b1;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

`ifdef REGFILE_SCHED_X0_ZERO_EN
    logic rs1_zero;
    logic rs2_zero;

    // Remember which operands addressed register 0 for the response in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rs1_zero <= 1'b0;
            rs2_zero <= 1'b0;
        end else if (rd_grant) begin
            rs1_zero <= (rd_rs1 == '0);
            rs2_zero <= (rd_rs2 == '0);
        end
    end

    // Operand return with register 0 forced to zero
    always_comb begin
        rsp_data1 = rs1_zero ? '0 : rf_readOut1;
        rsp_data2 = rs2_zero ? '0 : rf_readOut2;
    end
`else
    // Operand return straight from the RegFile read outputs
    always_comb begin
        rsp_data1 = rf_readOut1;
        rsp_data2 = rf_readOut2;
    end
`endif

endmodule

// File: tb/tb_regfile_sched.sv
// Self-checking bench for regfile_sched with a behavioural RegFile attached.
// Read responses are predicted from a shadow register array at read acceptance
// and compared in order as the controller returns them.
module tb_regfile_sched;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int WB = 4;

    logic          clk;
    logic          reset;
    logic          wr_valid, wr_ready;
    logic [AW-1:0] wr_rd;
    logic [DW-1:0] wr_data;
    logic          rd_valid, rd_ready;
    logic [AW-1:0] rd_rs1, rd_rs2;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_data1, rsp_data2;
    logic          busy;
    logic          rf_en, rf_reset, rf_rwen;
    logic [AW-1:0] rf_rs1, rf_rs2, rf_rd;
    logic [DW-1:0] rf_dataIn;
    logic [DW-1:0] rf_readOut1, rf_readOut2;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    logic [DW-1:0]   rf_mem [32];
    logic [DW-1:0]   shadow [32];
    logic [2*DW-1:0] sb_q [$];

    regfile_sched #(
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .WR_BURST(WB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_rd      (wr_rd),
        .wr_data    (wr_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_rs1     (rd_rs1),
        .rd_rs2     (rd_rs2),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data1  (rsp_data1),
        .rsp_data2  (rsp_data2),
        .busy       (busy),
        .rf_en      (rf_en),
        .rf_reset   (rf_reset),
        .rf_rwen    (rf_rwen),
        .rf_rs1     (rf_rs1),
        .rf_rs2     (rf_rs2),
        .rf_rd      (rf_rd),
        .rf_dataIn  (rf_dataIn),
        .rf_readOut1(rf_readOut1),
        .rf_readOut2(rf_readOut2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port RegFile: clear, dual registered read, or write
    always @(posedge clk) begin
        if (rf_en) begin
            if (rf_reset) begin
                for (int i = 0; i < 32; i++) rf_mem[i] <= '0;
            end else if (rf_rwen) begin
                rf_readOut1 <= rf_mem[rf_rs1];
                rf_readOut2 <= rf_mem[rf_rs2];
            end else begin
                rf_mem[rf_rd] <= rf_dataIn;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
`ifdef REGFILE_SCHED_X0_ZERO_EN
        if (a == '0) return '0;
`endif
        return shadow[a];
    endfunction

    // Scoreboard monitor: predict on handshake, compare while a response is shown
    initial begin
        forever begin
            @(negedge clk);
            if (!reset || busy) begin
                sb_q.delete();
                for (int i = 0; i < 32; i++) shadow[i] = '0;
            end else begin
                if (rsp_valid) begin
                    if (sb_q.size() == 0) begin
                        check("rsp_spurious", rsp_valid, 0);
                    end else begin
                        check("rsp_data", {rsp_data1, rsp_data2}, sb_q[0]);
                        if (rsp_ready) void'(sb_q.pop_front());
                    end
                end
                if (wr_valid && wr_ready) begin
`ifdef REGFILE_SCHED_X0_ZERO_EN
                    if (wr_rd != '0) shadow[wr_rd] = wr_data;
`else
                    shadow[wr_rd] = wr_data;
`endif
                end
                if (rd_valid && rd_ready) sb_q.push_back({exp_rd(rd_rs1), exp_rd(rd_rs2)});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called and returns just after a rising edge
    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int unsigned n;
        wr_valid = 1'b1;
        wr_rd    = a;
        wr_data  = d;
        n = 0;
        @(negedge clk);
        while (!wr_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (!wr_ready) check("wr_timeout", wr_ready, 1);
        step();
        wr_valid = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        int unsigned n;
        rd_valid = 1'b1;
        rd_rs1   = a1;
        rd_rs2   = a2;
        n = 0;
        @(negedge clk);
        while (!rd_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (!rd_ready) check("rd_timeout", rd_ready, 1);
        step();
        rd_valid = 1'b0;
    endtask

    logic        w_acc, r_acc;
    int unsigned wait_n;

    initial begin
        reset = 1'b0; rsp_ready = 1'b1;
        wr_valid = 1'b1; wr_rd = 5'd1; wr_data = 32'h1111_1111;
        rd_valid = 1'b1; rd_rs1 = 5'd1; rd_rs2 = 5'd2;

        // Held in reset with requests present
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 1);
        check("rst_rf_en", rf_en, 1);
        check("rst_rf_reset", rf_reset, 1);
        check("rst_wr_ready", wr_ready, 0);
        check("rst_rd_ready", rd_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        step();
        wr_valid = 1'b0; rd_valid = 1'b0; reset = 1'b1;

        // Single INIT cycle after release, then idle RUN
        @(negedge clk);
        check("init_busy", busy, 1);
        check("init_rf_reset", rf_reset, 1);
        check("init_rf_en", rf_en, 1);
        step();
        @(negedge clk);
        check("run_busy", busy, 0);
        check("run_idle_rf_en", rf_en, 0);
        step();

        // Cleared register reads back zero, response one cycle after grant
        do_read(5'd5, 5'd6);
        @(negedge clk);
        check("rd_latency", rsp_valid, 1);
        check("clr_x5", rsp_data1, 0);
        step();

        // Write then immediate read of the same register
        do_write(5'd3, 32'hDEAD_BEEF);
        do_read(5'd3, 5'd3);
        @(negedge clk);
        check("raw_valid", rsp_valid, 1);
        check("raw_d1", rsp_data1, 32'hDEAD_BEEF);
        check("raw_d2", rsp_data2, 32'hDEAD_BEEF);
        step();

        // Continuous write pressure against a waiting read
        wr_valid = 1'b1; rd_valid = 1'b1; rd_rs1 = 5'd10; rd_rs2 = 5'd11;
        for (int i = 0; i < 10; i++) begin
            wr_rd   = AW'(10 + (i % 4));
            wr_data = $urandom;
            @(negedge clk);
            check($sformatf("burst_w%0d", i), wr_ready, (i % 5) != 4);
            check($sformatf("burst_r%0d", i), rd_ready, (i % 5) == 4);
            step();
        end
        wr_valid = 1'b0; rd_valid = 1'b0;
        step(); step();

        // Stalled response: reads blocked, writes flow, data held
        rsp_ready = 1'b0;
        do_read(5'd3, 5'd10);
        rd_valid = 1'b1; rd_rs1 = 5'd3; rd_rs2 = 5'd4;
        wr_valid = 1'b1; wr_rd = 5'd3; wr_data = 32'hCAFE_F00D;
        @(negedge clk);
        check("stall_wr0", wr_ready, 1);
        check("stall_rd0", rd_ready, 0);
        step();
        wr_rd = 5'd4; wr_data = 32'h0BAD_F00D;
        @(negedge clk);
        check("stall_wr1", wr_ready, 1);
        check("stall_rd1", rd_ready, 0);
        step();
        wr_valid = 1'b0;
        @(negedge clk);
        check("stall_rd2", rd_ready, 0);
        check("stall_valid", rsp_valid, 1);
        check("stall_hold", rsp_data1, 32'hDEAD_BEEF);
        step();
        rsp_ready = 1'b1;
        @(negedge clk);
        check("stall_release", rd_ready, 1);
        step();
        rd_valid = 1'b0;
        @(negedge clk);
        check("post_stall_d1", rsp_data1, 32'hCAFE_F00D);
        check("post_stall_d2", rsp_data2, 32'h0BAD_F00D);
        step();

        // Register 0 behaviour
        wr_valid = 1'b1; wr_rd = 5'd0; wr_data = 32'h0000_1234;
        @(negedge clk);
        check("x0_wr_ready", wr_ready, 1);
`ifdef REGFILE_SCHED_X0_ZERO_EN
        check("x0_rf_en", rf_en, 0);
`else
        check("x0_rf_en", rf_en, 1);
`endif
        step();
        wr_valid = 1'b0;
        do_read(5'd0, 5'd3);
        @(negedge clk);
`ifdef REGFILE_SCHED_X0_ZERO_EN
        check("x0_read", rsp_data1, 0);
`else
        check("x0_read", rsp_data1, 32'h0000_1234);
`endif
        step();

        // Reset while a response is pending
        rsp_ready = 1'b0;
        do_read(5'd3, 5'd0);
        @(negedge clk);
        check("pre_rst_valid", rsp_valid, 1);
        #2 reset = 1'b0;
        #1;
        check("async_rsp_valid", rsp_valid, 0);
        check("async_busy", busy, 1);
        check("async_rf_reset", rf_reset, 1);
        step();
        reset = 1'b1; rsp_ready = 1'b1;
        @(negedge clk);
        check("rerst_init", busy, 1);
        step();
        do_read(5'd3, 5'd4);
        @(negedge clk);
        check("rerst_valid", rsp_valid, 1);
        check("rerst_x3", rsp_data1, 0);
        check("rerst_x4", rsp_data2, 0);
        step();

        // Random traffic with protocol-compliant request holding
        w_acc = 1'b0; r_acc = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (!wr_valid || w_acc) begin
                wr_valid = 1'($urandom_range(0, 1));
                wr_rd    = AW'($urandom_range(0, 7));
                wr_data  = $urandom;
            end
            if (!rd_valid || r_acc) begin
                rd_valid = 1'($urandom_range(0, 1));
                rd_rs1   = AW'($urandom_range(0, 7));
                rd_rs2   = AW'($urandom_range(0, 7));
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            w_acc = wr_valid && wr_ready;
            r_acc = rd_valid && rd_ready;
            check("one_grant", wr_ready && rd_ready, 0);
            if (!wr_valid) check("wr_ready_idle", wr_ready, 0);
            step();
        end

        // Drain outstanding responses
        wr_valid = 1'b0; rd_valid = 1'b0; rsp_ready = 1'b1;
        wait_n = 0;
        while (sb_q.size() != 0 && wait_n < 20) begin
            wait_n++;
            step();
        end
        check("drain", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
